// File: rtl/out_arbiter.sv
// Packet-aware two-input AXI-Stream round-robin arbiter with a single registered
// output stage; ownership is held for a whole packet or at most BURST_LEN beats.
module out_arbiter #(
  parameter int unsigned DWIDTH    = 128,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DWIDTH-1:0] s_axis_tdata_0,
  input  logic              s_axis_tvalid_0,
  input  logic              s_axis_tlast_0,
  output logic              s_axis_tready_0,
  input  logic [DWIDTH-1:0] s_axis_tdata_1,
  input  logic              s_axis_tvalid_1,
  input  logic              s_axis_tlast_1,
  output logic              s_axis_tready_1,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [1:0]        grant
);

  localparam int unsigned     CW       = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] tdata_q;
  logic              tvalid_q;
  logic              tlast_q;

  logic              out_free;
  logic              accept_0, accept_1, accept;
  logic [DWIDTH-1:0] beat_data;
  logic              beat_last;
  logic              release_grant;

  // The output slot is free when empty or being drained this cycle.
  assign out_free        = ~tvalid_q | m_axis_tready;
  assign s_axis_tready_0 = (state_q == GNT0) & out_free;
  assign s_axis_tready_1 = (state_q == GNT1) & out_free;

  assign accept_0  = s_axis_tvalid_0 & s_axis_tready_0;
  assign accept_1  = s_axis_tvalid_1 & s_axis_tready_1;
  assign accept    = accept_0 | accept_1;
  assign beat_data = accept_1 ? s_axis_tdata_1 : s_axis_tdata_0;
  assign beat_last = accept_1 ? s_axis_tlast_1 : s_axis_tlast_0;

  assign release_grant = accept & (beat_last | (cnt_q == CNT_LAST));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid_0 & s_axis_tvalid_1) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (s_axis_tvalid_0) begin
          state_d = GNT0;
        end else if (s_axis_tvalid_1) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (release_grant) begin
          state_d      = IDLE;
          last_grant_d = (state_q == GNT1);
          cnt_d        = '0;
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // A new accept takes priority over a drain, so a simultaneous consume/load
  // keeps tvalid high without losing or repeating a beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (accept) begin
      tdata_q  <= beat_data;
      tvalid_q <= 1'b1;
      tlast_q  <= beat_last;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  always_comb begin
    grant = 2'b00;
    case (state_q)
      GNT0:    grant = 2'b01;
      GNT1:    grant = 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_out_arbiter.sv
// Directed bench for out_arbiter: per-cycle vector table plus reactive stream
// sequences for the burst-limit and round-robin fairness cases.
module tb_out_arbiter;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] d0, d1;
  logic          v0, l0, v1, l1;
  logic          tr0, tr1;
  logic [DW-1:0] md;
  logic          mv, ml;
  logic          mrdy;
  logic [1:0]    gnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  out_arbiter #(.DWIDTH(DW), .BURST_LEN(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis_tdata_0  (d0),
    .s_axis_tvalid_0 (v0),
    .s_axis_tlast_0  (l0),
    .s_axis_tready_0 (tr0),
    .s_axis_tdata_1  (d1),
    .s_axis_tvalid_1 (v1),
    .s_axis_tlast_1  (l1),
    .s_axis_tready_1 (tr1),
    .m_axis_tdata    (md),
    .m_axis_tvalid   (mv),
    .m_axis_tlast    (ml),
    .m_axis_tready   (mrdy),
    .grant           (gnt)
  );

  typedef struct {
    logic          rst;
    logic          v0;
    logic [DW-1:0] d0;
    logic          l0;
    logic          v1;
    logic [DW-1:0] d1;
    logic          l1;
    logic          mr;
    logic [1:0]    g;
    logic          tr0;
    logic          tr1;
    logic          mv;
    logic [DW-1:0] md;
    logic          ml;
  } vec_t;

  vec_t vq[$];
  logic [DW:0] oq[$];
  logic [1:0]  gq[$];

  function automatic vec_t mk(logic rst, logic a_v, logic [DW-1:0] a_d, logic a_l,
                              logic b_v, logic [DW-1:0] b_d, logic b_l, logic mr,
                              logic [1:0] g, logic t0, logic t1,
                              logic ev, logic [DW-1:0] ed, logic el);
    vec_t v;
    v.rst = rst; v.v0 = a_v; v.d0 = a_d; v.l0 = a_l;
    v.v1 = b_v; v.d1 = b_d; v.l1 = b_l; v.mr = mr;
    v.g = g; v.tr0 = t0; v.tr1 = t1; v.mv = ev; v.md = ed; v.ml = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    v0 = 0; d0 = '0; l0 = 0; v1 = 0; d1 = '0; l1 = 0; mrdy = 1;
  endtask

  task automatic do_reset();
    rst_n = 0; idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Sources that present beat base+idx and advance only on a handshake.
  task automatic run_stream(input int n0, input int pl0, input logic [DW-1:0] b0,
                            input int n1, input int pl1, input logic [DW-1:0] b1,
                            input int ncyc);
    int i0 = 0;
    int i1 = 0;
    oq.delete(); gq.delete();
    for (int c = 0; c < ncyc; c++) begin
      v0 = (i0 < n0); d0 = b0 + DW'(i0); l0 = ((i0 + 1) % pl0 == 0) || (i0 == n0 - 1);
      v1 = (i1 < n1); d1 = b1 + DW'(i1); l1 = ((i1 + 1) % pl1 == 0) || (i1 == n1 - 1);
      mrdy = 1;
      @(negedge clk);
      gq.push_back(gnt);
      if (mv && mrdy) oq.push_back({ml, md});
      if (v0 && tr0) i0++;
      if (v1 && tr1) i1++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    logic [DW-1:0] bexp [14];
    logic [1:0]    ep [$];
    logic [1:0]    prev;
    int            cnt0, cnt1;

    rst_n = 0; idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // reset row
    vq.push_back(mk(0, 0,0,0, 0,0,0, 1, 2'b00,0,0, 0,0,0));
    // single-port 4-beat packet
    vq.push_back(mk(1, 1,16'hA000,0, 0,0,0, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 1,16'hA000,0, 0,0,0, 1, 2'b01,1,0, 0,0,0));
    vq.push_back(mk(1, 1,16'hA001,0, 0,0,0, 1, 2'b01,1,0, 1,16'hA000,0));
    vq.push_back(mk(1, 1,16'hA002,0, 0,0,0, 1, 2'b01,1,0, 1,16'hA001,0));
    vq.push_back(mk(1, 1,16'hA003,1, 0,0,0, 1, 2'b01,1,0, 1,16'hA002,0));
    vq.push_back(mk(1, 0,0,0,        0,0,0, 1, 2'b00,0,0, 1,16'hA003,1));
    vq.push_back(mk(1, 0,0,0,        0,0,0, 1, 2'b00,0,0, 0,0,0));
    // reset, then simultaneous 2-beat packets
    vq.push_back(mk(0, 0,0,0, 0,0,0, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 1,16'h0B00,0, 1,16'h1B00,0, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 1,16'h0B00,0, 1,16'h1B00,0, 1, 2'b01,1,0, 0,0,0));
    vq.push_back(mk(1, 1,16'h0B01,1, 1,16'h1B00,0, 1, 2'b01,1,0, 1,16'h0B00,0));
    vq.push_back(mk(1, 0,0,0,        1,16'h1B00,0, 1, 2'b00,0,0, 1,16'h0B01,1));
    vq.push_back(mk(1, 0,0,0,        1,16'h1B00,0, 1, 2'b10,0,1, 0,0,0));
    vq.push_back(mk(1, 0,0,0,        1,16'h1B01,1, 1, 2'b10,0,1, 1,16'h1B00,0));
    vq.push_back(mk(1, 0,0,0,        0,0,0,        1, 2'b00,0,0, 1,16'h1B01,1));
    vq.push_back(mk(1, 0,0,0,        0,0,0,        1, 2'b00,0,0, 0,0,0));
    // port-1 packet with 3 cycles of downstream backpressure holding B1
    vq.push_back(mk(1, 0,0,0, 1,16'hB000,0, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB000,0, 1, 2'b10,0,1, 0,0,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB001,0, 1, 2'b10,0,1, 1,16'hB000,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB002,0, 0, 2'b10,0,0, 1,16'hB001,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB002,0, 0, 2'b10,0,0, 1,16'hB001,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB002,0, 0, 2'b10,0,0, 1,16'hB001,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB002,0, 1, 2'b10,0,1, 1,16'hB001,0));
    vq.push_back(mk(1, 0,0,0, 1,16'hB003,1, 1, 2'b10,0,1, 1,16'hB002,0));
    vq.push_back(mk(1, 0,0,0, 0,0,0,        1, 2'b00,0,0, 1,16'hB003,1));
    vq.push_back(mk(1, 0,0,0, 0,0,0,        1, 2'b00,0,0, 0,0,0));
    // reset mid-packet after two beats, then a tie must go to port 0
    vq.push_back(mk(1, 1,16'hC000,0, 0,0,0, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 1,16'hC000,0, 0,0,0, 1, 2'b01,1,0, 0,0,0));
    vq.push_back(mk(1, 1,16'hC001,0, 0,0,0, 1, 2'b01,1,0, 1,16'hC000,0));
    vq.push_back(mk(0, 0,0,0,        0,0,0, 1, 2'b01,1,0, 1,16'hC001,0));
    vq.push_back(mk(1, 1,16'hD000,1, 1,16'hE000,1, 1, 2'b00,0,0, 0,0,0));
    vq.push_back(mk(1, 1,16'hD000,1, 1,16'hE000,1, 1, 2'b01,1,0, 0,0,0));
    vq.push_back(mk(1, 0,0,0,        1,16'hE000,1, 1, 2'b00,0,0, 1,16'hD000,1));
    vq.push_back(mk(1, 0,0,0,        1,16'hE000,1, 1, 2'b10,0,1, 0,0,0));
    vq.push_back(mk(1, 0,0,0,        0,0,0,        1, 2'b00,0,0, 1,16'hE000,1));
    vq.push_back(mk(1, 0,0,0,        0,0,0,        1, 2'b00,0,0, 0,0,0));

    foreach (vq[i]) begin
      rst_n = vq[i].rst;
      v0 = vq[i].v0; d0 = vq[i].d0; l0 = vq[i].l0;
      v1 = vq[i].v1; d1 = vq[i].d1; l1 = vq[i].l1;
      mrdy = vq[i].mr;
      @(negedge clk);
      chk($sformatf("row%0d grant", i), 32'(gnt), 32'(vq[i].g));
      chk($sformatf("row%0d tready0", i), 32'(tr0), 32'(vq[i].tr0));
      chk($sformatf("row%0d tready1", i), 32'(tr1), 32'(vq[i].tr1));
      chk($sformatf("row%0d m_tvalid", i), 32'(mv), 32'(vq[i].mv));
      if (vq[i].mv) begin
        chk($sformatf("row%0d m_tdata", i), 32'(md), 32'(vq[i].md));
        chk($sformatf("row%0d m_tlast", i), 32'(ml), 32'(vq[i].ml));
      end
      @(posedge clk); #1;
    end

    // Burst limit 4: port 0 sends 10 beats, port 1 never ends its packet.
    do_reset();
    run_stream(10, 10, 16'h2000, 1000, 1000, 16'h3000, 40);
    bexp = '{16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h3000, 16'h3001, 16'h3002,
             16'h3003, 16'h2004, 16'h2005, 16'h2006, 16'h2007, 16'h3004, 16'h3005};
    chk("burst beat_count_ok", 32'(oq.size() >= 14), 32'd1);
    for (int k = 0; k < 14 && k < oq.size(); k++) begin
      chk($sformatf("burst beat%0d data", k), 32'(oq[k][DW-1:0]), 32'(bexp[k]));
      chk($sformatf("burst beat%0d last", k), 32'(oq[k][DW]), 32'd0);
    end
    prev = 2'b00;
    ep.delete();
    foreach (gq[k]) begin
      if (prev == 2'b00 && gq[k] != 2'b00) ep.push_back(gq[k]);
      prev = gq[k];
    end
    chk("burst grant_episodes_ok", 32'(ep.size() >= 6), 32'd1);
    for (int k = 0; k < 6 && k < ep.size(); k++)
      chk($sformatf("burst episode%0d grant", k), 32'(ep[k]), (k % 2 == 0) ? 32'd1 : 32'd2);

    // Tail of port 0 (2008, 2009 with tlast) follows the second port-1 burst.
    do_reset();
    run_stream(10, 10, 16'h2000, 1000, 1000, 16'h3000, 40);
    chk("burst tail_count_ok", 32'(oq.size() >= 18), 32'd1);
    if (oq.size() >= 18) begin
      chk("burst tail beat16", 32'(oq[16]), 32'({1'b0, 16'h2008}));
      chk("burst tail beat17", 32'(oq[17]), 32'({1'b1, 16'h2009}));
    end

    // Round-robin fairness with 1-beat packets on both ports.
    do_reset();
    run_stream(1000, 1, 16'h4000, 1000, 1, 16'h5000, 41);
    for (int k = 0; k < 41; k++) begin
      logic [1:0] eg;
      eg = (k % 2 == 0) ? 2'b00 : ((((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr cycle%0d grant", k), 32'(gq[k]), 32'(eg));
    end
    chk("rr beat_count", 32'(oq.size()), 32'd20);
    cnt0 = 0; cnt1 = 0;
    foreach (oq[k]) begin
      logic [DW-1:0] ed;
      ed = ((k % 2 == 0) ? 16'h4000 : 16'h5000) + DW'(k / 2);
      chk($sformatf("rr beat%0d", k), 32'(oq[k]), 32'({1'b1, ed}));
      if (oq[k][DW-1:12] == 4'h4) cnt0++;
      if (oq[k][DW-1:12] == 4'h5) cnt1++;
    end
    chk("rr port0_served", 32'(cnt0), 32'd10);
    chk("rr port1_served", 32'(cnt1), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/out_arbiter.md
# out_arbiter

Packet-aware two-input AXI-Stream round-robin arbiter. It drives the merged output stream of the data-route output stage. Unlike a plain OR-merge, it guarantees that only one requester owns the output at a time. Ownership is held for a whole packet (up to `tlast`) or a bounded burst. Data leaves through a single registered output stage with full backpressure.

## Interface
- `DWIDTH`, 128, data width of all streams.
- `BURST_LEN`, 16, maximum beats per grant before forced release (≥1).

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `s_axis_tdata_0`  in  DWIDTH  requester 0 data.
- `s_axis_tvalid_0`  in  1  requester 0 valid.
- `s_axis_tlast_0`  in  1  requester 0 end of packet.
- `s_axis_tready_0`  out  1  requester 0 ready.
- `s_axis_tdata_1`  in  DWIDTH  requester 1 data.
- `s_axis_tvalid_1`  in  1  requester 1 valid.
- `s_axis_tlast_1`  in  1  requester 1 end of packet.
- `s_axis_tready_1`  out  1  requester 1 ready.
- `m_axis_tdata`  out  DWIDTH  merged data (registered).
- `m_axis_tvalid`  out  1  merged valid (registered).
- `m_axis_tlast`  out  1  merged last (registered).
- `m_axis_tready`  in  1  downstream ready.
- `grant`  out  2  one-hot current owner; `00` = none.

## Operation
- **FSM states.** IDLE, GNT0, GNT1.
  - `last_grant` register records the most recently served port.
  - Beat counter `cnt` is `$clog2(BURST_LEN+1)` bits wide.
- **IDLE.**
  - If exactly one `tvalid_x` is high, go to GNTx.
  - If both are high, go to the port ≠ `last_grant`.
  - If neither is high, stay in IDLE.
  - Both `s_axis_tready_x` are 0 in IDLE.
- **GNTx.**
  - `s_axis_tready_x` = `out_free`, where `out_free` = `~m_axis_tvalid | m_axis_tready`.
  - The other port's tready is 0.
  - `grant[x]` = 1.
- **Beat accept.** A beat is accepted when `s_axis_tvalid_x & s_axis_tready_x`. On accept:
  - Register data and tlast into the output.
  - Set `m_axis_tvalid` to 1.
  - `cnt` increments.
- **Release.** Return to IDLE, set `last_grant` = x and clear `cnt` when either condition is met:
  - the accepted beat has tlast = 1, or
  - `cnt` reaches `BURST_LEN` (i.e. the accepted beat is the BURST_LEN-th).
- **Output register.**
  - If an output beat is consumed (`m_axis_tvalid & m_axis_tready`) with no new accept, `m_axis_tvalid` goes to 0.
  - If both happen in the same cycle, the register reloads and `m_axis_tvalid` stays at 1.
  - While `m_axis_tvalid & ~m_axis_tready`, `m_axis_tdata` and `m_axis_tlast` hold stable.
- **Granted requester drops tvalid.** The grant is held and `cnt` does not advance. There is no timeout.
- **Non-granted requester.** Its tvalid, data and tlast are ignored; it is never dropped.
- **Reset values** (any cycle, including mid-packet):
  - state IDLE, `last_grant` = 1 (port 0 wins the first tie), `cnt` = 0;
  - `m_axis_tdata` = 0, `m_axis_tvalid` = 0, `m_axis_tlast` = 0;
  - `s_axis_tready_0/1` = 0, `grant` = 00.
  - A partial packet in flight is abandoned. The output does not complete it.

## Timing
- Input-to-output latency: 1 cycle.
  - A beat accepted at the edge ending cycle N appears with `m_axis_tvalid` = 1 in cycle N+1.
- Grant latency: 1 cycle.
  - IDLE samples valid in cycle N.
  - GNTx and `s_axis_tready_x` are active in cycle N+1.
  - The first beat can transfer at the end of cycle N+1.
- Throughput: 1 beat/cycle within a grant when `m_axis_tready` is held high.
- Each release costs exactly one IDLE bubble cycle on the input side before the next grant.
- `s_axis_tready_x` depends combinationally on `m_axis_tready` and registered state only. It never depends on any `s_axis_tvalid`.
- `grant` is a registered decode of the state: 01 in GNT0, 10 in GNT1, 00 in IDLE.
- The full-duplex accept/consume case (tready and tvalid both high) must not lose or duplicate a beat.

## Test plan
- **Single-port packet.** Port 0 sends a 4-beat packet (A0..A3, tlast on A3), with `m_axis_tready` = 1 and port 1 idle.
  - Required: grant 01 from cycle 1; output A0..A3 in cycles 2–5 with tlast on A3; grant 00 in cycle 5.
- **Simultaneous request tie.** Both ports assert a 2-beat packet in cycle 0 after reset.
  - Required: port 0 packet fully output first, then one idle input cycle, then port 1 packet.
  - Output order: P0b0, P0b1, P1b0, P1b1; no beats interleaved.
- **Backpressure.** During a port-1 packet, hold `m_axis_tready` = 0 for 3 cycles while output holds beat B1.
  - Required: `m_axis_tdata` = B1 stable; `s_axis_tready_1` = 0 for those cycles; B2 follows with no loss or duplication.
- **Burst limit.** With `BURST_LEN` = 4, port 0 sends a 10-beat packet and port 1 is continuously valid.
  - Required: output is 4 beats of port 0, 4 of port 1 (or port 1's packet end), then the remaining port 0 beats.
  - Grant alternates at each release.
- **Round-robin fairness.** Both ports continuously send 1-beat packets for 20 grants.
  - Required: grant strictly alternates 01, 10, 01, …, each port is served 10 times, and there is 1 idle cycle between grants.
- **Reset mid-packet.** Assert `rst_n` = 0 for 1 cycle after beat 2 of a 5-beat port-0 packet.
  - Required: next cycle all outputs at reset values; the next tie grants port 0.
